ro_puf_ctrl: RTL and testbench
==============================

Name: ro_puf_ctrl

Overview:
- Parametrised controller for a ring-oscillator PUF built from chains of enable slices. It holds N_RO oscillators, each an external chain of enable slices.
- Per challenge it picks two oscillators, enables only those, and counts their rising edges over a fixed window. The response bit is the comparison of the two counts.
- It sits between the challenge source (UART/host FSM) and the oscillator array, replacing hand-wired single-slice enables.

Parameters:
- N_RO, 16, number of oscillator inputs (power of 2, >=2)
- SEL_W, $clog2(N_RO), oscillator index width
- CNT_W, 16, edge counter width
- SETTLE_CYC, 8, cycles oscillators run before counting starts
- WINDOW, 4096, counting window in clk cycles (>=4)

Ports:
- clk  input  1  system clock
- rst_n  input  1  synchronous active-low reset
- start  input  1  request; accepted only in IDLE
- challenge  input  2*SEL_W  [SEL_W-1:0]=sel_a, [2*SEL_W-1:SEL_W]=sel_b; sampled on accepted start
- ro_en  output  N_RO  per-oscillator enable to slice chains
- ro_in  input  N_RO  raw oscillator outputs, asynchronous to clk
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse, result valid
- response  output  1  1 when count_a > count_b
- tie  output  1  count_a == count_b
- err  output  1  illegal challenge (sel_a == sel_b)
- count_a  output  CNT_W  final edge count of sel_a
- count_b  output  CNT_W  final edge count of sel_b

Behaviour:
- Reset: all outputs 0, ro_en all 0, FSM in IDLE, counters and synchronisers cleared. Reset is synchronous and applies mid-operation: the next cycle is IDLE with ro_en=0 and no done pulse.
- FSM states: IDLE, SETTLE, COUNT, DONE.
- IDLE, start=1, sel_a != sel_b:
  - latch sel_a and sel_b; clear counters and the timer; go to SETTLE.
  - ro_en[sel_a] and ro_en[sel_b] go high in the next cycle. No other bit is ever set.
- IDLE, start=1, sel_a == sel_b:
  - go to DONE directly with err=1, response=0, tie=0, counts=0.
  - ro_en stays 0.
- SETTLE: lasts exactly SETTLE_CYC cycles, then go to COUNT. Edges are not counted.
- COUNT:
  - lasts exactly WINDOW cycles.
  - each selected ro_in passes through a 2-flop synchroniser plus an edge-detect flop.
  - every synchronised 0->1 transition seen during COUNT increments its counter.
  - counters saturate at 2^CNT_W-1 and never wrap.
  - the synchroniser runs continuously, so the pipeline is full when COUNT begins.
- Leaving COUNT:
  - ro_en returns to all 0.
  - count_a, count_b, response and tie are registered.
  - state goes to DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
- response, tie, err and counts hold their values until the next accepted start, which clears err.
- Latency: start accepted at cycle T gives done at T+1+SETTLE_CYC+WINDOW. An err case gives done at T+1.
- busy is 1 from T+1 through the DONE cycle inclusive.
- start while busy is ignored, with no queuing. start held high in DONE is not accepted until the IDLE cycle.
- Simultaneous edges on both oscillators in one cycle increment both counters.
- challenge changes after acceptance have no effect.
- An oscillator toggling faster than clk/2 aliases. This is documented and not detected.

Test Plan:
1. Basic compare. Params: N_RO=16, SETTLE_CYC=4, WINDOW=64.
   - Stimulus: ro_in[3] period 4 clk, ro_in[5] period 8 clk, challenge sel_a=3 sel_b=5, start pulse.
   - Required: done exactly 69 cycles after the accept cycle; count_a in 15..17, count_b in 7..9; response=1, tie=0, err=0.
   - ro_en=16'h0028 only during SETTLE and COUNT.
2. Swapped challenge (sel_a=5, sel_b=3), same stimulus:
   - Required: response=0, tie=0, counts swapped.
3. Illegal challenge sel_a=sel_b=7:
   - Required: done one cycle after accept, err=1, response=0; ro_en never nonzero.
4. Tie and saturation, with CNT_W=4 and both oscillators at period 2:
   - Required: count_a=count_b=15 (saturated), tie=1, response=0.
5. start re-asserted every cycle during busy:
   - Required: exactly one done per operation; second op starts only after IDLE; challenge latched at the first accept only.
6. rst_n low for 1 cycle mid-COUNT:
   - Required: next cycle busy=0, ro_en=0, all outputs 0; no done pulse; a fresh start then completes normally.

Source files
------------

// File: rtl/ro_puf_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ro_puf_ctrl
// Description : Ring-oscillator PUF controller; enables two oscillators,
//               counts their edges over a fixed window and compares them.
// Revision    : 1.0 - initial release
// ============================================================================
module ro_puf_ctrl #(
    parameter int N_RO       = 16,
    parameter int SEL_W      = $clog2(N_RO),
    parameter int CNT_W      = 16,
    parameter int SETTLE_CYC = 8,
    parameter int WINDOW     = 4096
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [2*SEL_W-1:0]   challenge,
    output logic [N_RO-1:0]      ro_en,
    input  logic [N_RO-1:0]      ro_in,
    output logic                 busy,
    output logic                 done,
    output logic                 response,
    output logic                 tie,
    output logic                 err,
    output logic [CNT_W-1:0]     count_a,
    output logic [CNT_W-1:0]     count_b
);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_SETTLE = 2'd1;
    localparam logic [1:0] c_ST_COUNT  = 2'd2;
    localparam logic [1:0] c_ST_DONE   = 2'd3;

    localparam int c_TMR_MAX = (SETTLE_CYC > WINDOW) ? SETTLE_CYC : WINDOW;
    localparam int c_TMR_W   = $clog2(c_TMR_MAX + 1);
    localparam logic [c_TMR_W-1:0] c_SETTLE_LAST = c_TMR_W'(SETTLE_CYC - 1);
    localparam logic [c_TMR_W-1:0] c_WINDOW_LAST = c_TMR_W'(WINDOW - 1);
    localparam logic [CNT_W-1:0]   c_CNT_MAX     = {CNT_W{1'b1}};

    logic [1:0]         r_state;
    logic [SEL_W-1:0]   r_selA;
    logic [SEL_W-1:0]   r_selB;
    logic [c_TMR_W-1:0] r_timer;
    logic [CNT_W-1:0]   r_cntA;
    logic [CNT_W-1:0]   r_cntB;
    logic [N_RO-1:0]    r_sync1;
    logic [N_RO-1:0]    r_sync2;
    logic [N_RO-1:0]    r_syncPrev;

    logic [SEL_W-1:0]   w_chalA;
    logic [SEL_W-1:0]   w_chalB;
    logic [N_RO-1:0]    w_rise;
    logic [CNT_W-1:0]   w_nextA;
    logic [CNT_W-1:0]   w_nextB;

    assign w_chalA = challenge[SEL_W-1:0];
    assign w_chalB = challenge[2*SEL_W-1:SEL_W];
    assign w_rise  = r_sync2 & ~r_syncPrev;

    // Saturating increments; the final COUNT cycle's edge is folded into the result.
    always_comb begin
        w_nextA = r_cntA;
        w_nextB = r_cntB;
        if (w_rise[r_selA] && (r_cntA != c_CNT_MAX)) w_nextA = r_cntA + CNT_W'(1);
        if (w_rise[r_selB] && (r_cntB != c_CNT_MAX)) w_nextB = r_cntB + CNT_W'(1);
    end

    // Synchronisers run free so the edge pipeline is already primed when COUNT begins.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1    <= '0;
            r_sync2    <= '0;
            r_syncPrev <= '0;
        end else begin
            r_sync1    <= ro_in;
            r_sync2    <= r_sync1;
            r_syncPrev <= r_sync2;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= c_ST_IDLE;
            r_selA   <= '0;
            r_selB   <= '0;
            r_timer  <= '0;
            r_cntA   <= '0;
            r_cntB   <= '0;
            ro_en    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            response <= 1'b0;
            tie      <= 1'b0;
            err      <= 1'b0;
            count_a  <= '0;
            count_b  <= '0;
        end else begin
            done <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        if (w_chalA == w_chalB) begin
                            r_state  <= c_ST_DONE;
                            done     <= 1'b1;
                            err      <= 1'b1;
                            response <= 1'b0;
                            tie      <= 1'b0;
                            count_a  <= '0;
                            count_b  <= '0;
                        end else begin
                            r_state <= c_ST_SETTLE;
                            err     <= 1'b0;
                            r_selA  <= w_chalA;
                            r_selB  <= w_chalB;
                            r_timer <= '0;
                            r_cntA  <= '0;
                            r_cntB  <= '0;
                            ro_en   <= (N_RO'(1) << w_chalA) | (N_RO'(1) << w_chalB);
                        end
                    end
                end
                c_ST_SETTLE: begin
                    if (r_timer == c_SETTLE_LAST) begin
                        r_timer <= '0;
                        r_state <= c_ST_COUNT;
                    end else begin
                        r_timer <= r_timer + c_TMR_W'(1);
                    end
                end
                c_ST_COUNT: begin
                    r_cntA <= w_nextA;
                    r_cntB <= w_nextB;
                    if (r_timer == c_WINDOW_LAST) begin
                        ro_en    <= '0;
                        count_a  <= w_nextA;
                        count_b  <= w_nextB;
                        response <= (w_nextA > w_nextB);
                        tie      <= (w_nextA == w_nextB);
                        done     <= 1'b1;
                        r_state  <= c_ST_DONE;
                    end else begin
                        r_timer <= r_timer + c_TMR_W'(1);
                    end
                end
                c_ST_DONE: begin
                    busy    <= 1'b0;
                    r_state <= c_ST_IDLE;
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ro_puf_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_ro_puf_ctrl
// Description : Self-checking bench for ro_puf_ctrl (16-bit and 4-bit counters).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ro_puf_ctrl;

    localparam int N_RO   = 16;
    localparam int SETTLE = 4;
    localparam int WIN    = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  challenge = '0;
    logic [15:0] roIn = '0;

    logic [15:0] roEn, sRoEn;
    logic        busy, done, response, tie, err;
    logic        sBusy, sDone, sResponse, sTie, sErr;
    logic [15:0] countA, countB;
    logic [3:0]  sCountA, sCountB;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int per[16];
    bit checkOn = 1'b0;

    // Behavioural model: countdown of remaining busy cycles from the accept.
    bit          mBusy = 1'b0;
    bit          mRst = 1'b0;
    bit          mErr = 1'b0;
    int          mRem = 0;
    int          mExpA = 0;
    int          mExpB = 0;
    logic [15:0] mRoEn = '0;

    ro_puf_ctrl #(.N_RO(N_RO), .CNT_W(16), .SETTLE_CYC(SETTLE), .WINDOW(WIN)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .challenge(challenge),
        .ro_en(roEn), .ro_in(roIn), .busy(busy), .done(done),
        .response(response), .tie(tie), .err(err),
        .count_a(countA), .count_b(countB)
    );

    ro_puf_ctrl #(.N_RO(N_RO), .CNT_W(4), .SETTLE_CYC(SETTLE), .WINDOW(WIN)) u_sat (
        .clk(clk), .rst_n(rst_n), .start(start), .challenge(challenge),
        .ro_en(sRoEn), .ro_in(roIn), .busy(sBusy), .done(sDone),
        .response(sResponse), .tie(sTie), .err(sErr),
        .count_a(sCountA), .count_b(sCountB)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic checkRange(input string name, input logic [31:0] act, input int lo, input int hi);
        total++;
        if ((^act === 1'bx) || (act < lo) || (act > hi)) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d..%0d (cycle %0d)", name, act, lo, hi, cyc);
        end
    endtask

    function automatic int ideal(input int idx);
        return (per[idx] >= 2) ? WIN / per[idx] : 0;
    endfunction

    function automatic int clampTo(input int v, input int cmax);
        return (v > cmax) ? cmax : v;
    endfunction

    always @(negedge clk) begin
        for (int i = 0; i < 16; i++)
            roIn[i] = (per[i] >= 2) ? (((cyc / (per[i] / 2)) % 2) != 0) : 1'b0;
    end

    always @(posedge clk) begin
        cyc = cyc + 1;
        mRst = 1'b0;
        if (!rst_n) begin
            mBusy = 1'b0; mRem = 0; mRoEn = '0; mRst = 1'b1;
        end else if (!mBusy) begin
            if (start) begin
                mBusy = 1'b1;
                if (challenge[3:0] == challenge[7:4]) begin
                    mErr = 1'b1; mRem = 0; mRoEn = '0; mExpA = 0; mExpB = 0;
                end else begin
                    mErr  = 1'b0;
                    mRem  = SETTLE + WIN;
                    mRoEn = '0;
                    mRoEn[challenge[3:0]] = 1'b1;
                    mRoEn[challenge[7:4]] = 1'b1;
                    mExpA = ideal(int'(challenge[3:0]));
                    mExpB = ideal(int'(challenge[7:4]));
                end
            end
        end else if (mRem == 0) begin
            mBusy = 1'b0;
        end else begin
            mRem = mRem - 1;
            if (mRem == 0) mRoEn = '0;
        end
    end

    task automatic checkResult(input string tag, input int cmax, input logic e, input logic r,
                               input logic t, input logic [15:0] ca, input logic [15:0] cb);
        int xa, xb;
        if (mErr) begin
            check({tag, ".err"}, 32'(e), 32'd1);
            check({tag, ".response"}, 32'(r), 32'd0);
            check({tag, ".tie"}, 32'(t), 32'd0);
            check({tag, ".count_a"}, 32'(ca), 32'd0);
            check({tag, ".count_b"}, 32'(cb), 32'd0);
        end else begin
            xa = clampTo(mExpA, cmax);
            xb = clampTo(mExpB, cmax);
            check({tag, ".err"}, 32'(e), 32'd0);
            checkRange({tag, ".count_a"}, 32'(ca), clampTo((mExpA > 0) ? mExpA - 1 : 0, cmax), clampTo(mExpA + 1, cmax));
            checkRange({tag, ".count_b"}, 32'(cb), clampTo((mExpB > 0) ? mExpB - 1 : 0, cmax), clampTo(mExpB + 1, cmax));
            check({tag, ".tie"}, 32'(t), 32'(xa == xb));
            check({tag, ".response"}, 32'(r), 32'(xa > xb));
        end
    endtask

    always @(negedge clk) begin
        if (checkOn) begin
            check("busy", 32'(busy), 32'(mBusy));
            check("sat.busy", 32'(sBusy), 32'(mBusy));
            check("done", 32'(done), 32'(mBusy && mRem == 0));
            check("sat.done", 32'(sDone), 32'(mBusy && mRem == 0));
            check("ro_en", 32'(roEn), 32'(mRoEn));
            check("sat.ro_en", 32'(sRoEn), 32'(mRoEn));
            if (mRst) begin
                check("rst.flags", {27'd0, response, tie, err, sResponse, sTie}, 32'd0);
                check("rst.counts", {countA | countB, 8'd0, sCountA, sCountB}, 32'd0);
                check("rst.serr", 32'(sErr), 32'd0);
            end
            if (mBusy && mRem == 0) begin
                checkResult("dut", 65535, err, response, tie, countA, countB);
                checkResult("sat", 15, sErr, sResponse, sTie, {12'd0, sCountA}, {12'd0, sCountB});
            end
        end
    end

    task automatic doOp(input logic [3:0] a, input logic [3:0] b, output int lat);
        @(negedge clk);
        challenge = {b, a};
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        challenge = 8'hFF;
        lat = 1;
        while (done !== 1'b1 && lat < 300) begin
            @(negedge clk);
            lat++;
        end
        if (done !== 1'b1) begin
            total++; bad++;
            $display("FAIL timeout: no done within %0d cycles", lat);
        end
    endtask

    initial begin
        int lat;
        int doneCnt;
        for (int i = 0; i < 16; i++) per[i] = 0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checkOn = 1'b1;
        check("reset.busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        per[3] = 4; per[5] = 8;

        doOp(4'd3, 4'd5, lat);
        check("t1.latency", 32'(lat), 32'd69);
        checkRange("t1.count_a", 32'(countA), 15, 17);
        checkRange("t1.count_b", 32'(countB), 7, 9);
        check("t1.response", 32'(response), 32'd1);

        doOp(4'd5, 4'd3, lat);
        check("t2.response", 32'(response), 32'd0);
        checkRange("t2.count_a", 32'(countA), 7, 9);

        doOp(4'd7, 4'd7, lat);
        check("t3.latency", 32'(lat), 32'd1);
        check("t3.err", 32'(err), 32'd1);

        per[3] = 2; per[5] = 2;
        doOp(4'd3, 4'd5, lat);
        check("t4.sat_count_a", 32'(sCountA), 32'd15);
        check("t4.sat_tie", 32'(sTie), 32'd1);
        per[3] = 4; per[5] = 8;

        doneCnt = 0;
        @(negedge clk);
        for (int i = 0; i < 200; i++) begin
            start = (i < 100);
            challenge = (i % 2 == 0) ? 8'h53 : 8'h29;
            @(negedge clk);
            if (done === 1'b1) doneCnt++;
        end
        start = 1'b0;
        check("t5.done_count", 32'(doneCnt), 32'd2);

        doOp(4'd3, 4'd5, lat);
        @(negedge clk);
        challenge = 8'h53;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (30) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("t6.busy", 32'(busy), 32'd0);
        check("t6.ro_en", 32'(roEn), 32'd0);
        rst_n = 1'b1;
        doneCnt = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (done === 1'b1) doneCnt++;
        end
        check("t6.no_done", 32'(doneCnt), 32'd0);
        doOp(4'd3, 4'd5, lat);
        check("t6.latency", 32'(lat), 32'd69);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
